// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 display controller.
package lcd_pkg;

  typedef enum logic [2:0] {StPowerup, StInit, StIdle, StConv, StWrite} state_e;
  typedef enum logic [1:0] {PhSetup, PhEn, PhWait} phase_e;

  typedef logic [7:0] lcd_byte_t;

  localparam lcd_byte_t FUNC_SET = 8'h38;
  localparam lcd_byte_t DISP_ON  = 8'h0C;
  localparam lcd_byte_t CLEAR    = 8'h01;
  localparam lcd_byte_t ENTRY    = 8'h06;
  localparam lcd_byte_t ADDR0    = 8'h80;

  localparam lcd_byte_t SPACE = 8'h20;
  localparam lcd_byte_t MINUS = 8'h2D;
  localparam lcd_byte_t ZERO  = 8'h30;

  // Last byte index of the init sequence and of a refresh (address + 6 chars).
  localparam logic [2:0] INIT_LAST  = 3'd3;
  localparam logic [2:0] WRITE_LAST = 3'd6;

  function automatic lcd_byte_t digit_char(input logic [3:0] d);
    return ZERO + {4'h0, d};
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// CPU-side value/strobe and LCD parallel bus grouped for lcd_ctrl.
interface lcd_ctrl_if;
  logic [15:0]       data_in;
  logic              update;
  logic              busy;
  logic              lcd_rs;
  logic              lcd_rw;
  logic              lcd_en;
  lcd_pkg::lcd_byte_t lcd_db;

  modport master (
    output data_in, update,
    input  busy, lcd_rs, lcd_rw, lcd_en, lcd_db
  );

  modport slave (
    input  data_in, update,
    output busy, lcd_rs, lcd_rw, lcd_en, lcd_db
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: load on start, then 16 shift cycles.
// done is high in the final shift cycle; bcd holds the result from the next cycle on.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] mag,
  output logic        done,
  output logic [19:0] bcd
);

  logic [15:0] sr_q, sr_d;
  logic [19:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [19:0] adj;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    sr_d  = sr_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (start) begin
      sr_d  = mag;
      bcd_d = '0;
      cnt_d = 5'd16;
    end else if (cnt_q != 5'd0) begin
      {bcd_d, sr_d} = {adj[18:0], sr_q, 1'b0};
      cnt_d         = cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == 5'd1) && !start;
  assign bcd  = bcd_q;

endmodule

// File: rtl/lcd_ctrl.sv
// Signed 16-bit value to six ASCII characters on an HD44780 LCD, with power-up/init.
// Build option: LCD_ZERO_BLANK_EN blanks leading zeros in columns 1-4.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_CLEAR   = 82000,
  parameter int unsigned T_EN      = 12
) (
  input logic       clk,
  input logic       reset,
  lcd_ctrl_if.slave bus
);

  localparam int unsigned CntMax = max_u(max_u(T_POWERUP, T_CLEAR), max_u(T_CMD, T_EN));
  localparam int unsigned CntW   = (CntMax < 2) ? 1 : $clog2(CntMax);

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [15:0]       value_q, value_d, pend_val_q, pend_val_d;
  logic              pend_q, pend_d, start_q, start_d, armed_q;
  logic              upd, conv_done, cur_rs;
  logic [CntW-1:0]   wait_last;
  logic [15:0]       mag;
  logic [19:0]       bcd;
  logic [3:0]        lead;
  lcd_byte_t         cur_byte;

  assign mag = value_q[15] ? (~value_q + 16'd1) : value_q;
  // A strobe in the first cycle after reset release is dropped.
  assign upd = bus.update && armed_q;

  bin2bcd_seq u_bin2bcd (
    .clk  (clk),
    .reset(reset),
    .start(start_q),
    .mag  (mag),
    .done (conv_done),
    .bcd  (bcd)
  );

  always_comb begin
    lead = '0;
`ifdef LCD_ZERO_BLANK_EN
    lead[0] = (bcd[19:16] == 4'd0);
    lead[1] = lead[0] && (bcd[15:12] == 4'd0);
    lead[2] = lead[1] && (bcd[11:8] == 4'd0);
    lead[3] = lead[2] && (bcd[7:4] == 4'd0);
`endif
    cur_byte = 8'h00;
    cur_rs   = 1'b0;
    unique case (state_q)
      StInit: begin
        case (idx_q)
          3'd0:    cur_byte = FUNC_SET;
          3'd1:    cur_byte = DISP_ON;
          3'd2:    cur_byte = CLEAR;
          default: cur_byte = ENTRY;
        endcase
      end
      StWrite: begin
        cur_rs = (idx_q != 3'd0);
        case (idx_q)
          3'd0:    cur_byte = ADDR0;
          3'd1:    cur_byte = value_q[15] ? MINUS : SPACE;
          3'd2:    cur_byte = lead[0] ? SPACE : digit_char(bcd[19:16]);
          3'd3:    cur_byte = lead[1] ? SPACE : digit_char(bcd[15:12]);
          3'd4:    cur_byte = lead[2] ? SPACE : digit_char(bcd[11:8]);
          3'd5:    cur_byte = lead[3] ? SPACE : digit_char(bcd[7:4]);
          default: cur_byte = digit_char(bcd[3:0]);
        endcase
      end
      default: ;
    endcase
    wait_last = (!cur_rs && cur_byte == CLEAR) ? CntW'(T_CLEAR - 1) : CntW'(T_CMD - 1);
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    value_d    = value_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    start_d    = 1'b0;
    if (upd && state_q != StIdle) begin
      pend_d     = 1'b1;
      pend_val_d = bus.data_in;
    end
    unique case (state_q)
      StPowerup: begin
        if (cnt_q == CntW'(T_POWERUP - 1)) begin
          cnt_d   = '0;
          state_d = StInit;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle: begin
        if (upd) begin
          value_d = bus.data_in;
          start_d = 1'b1;
          state_d = StConv;
        end
      end
      StConv: begin
        if (conv_done) begin
          state_d = StWrite;
          phase_d = PhSetup;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      StInit, StWrite: begin
        unique case (phase_q)
          PhSetup: begin
            phase_d = PhEn;
            cnt_d   = '0;
          end
          PhEn: begin
            if (cnt_q == CntW'(T_EN - 1)) begin
              phase_d = PhWait;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            if (cnt_q == wait_last) begin
              cnt_d   = '0;
              phase_d = PhSetup;
              if (idx_q == ((state_q == StInit) ? INIT_LAST : WRITE_LAST)) begin
                idx_d = '0;
                // A queued refresh skips IDLE so busy never drops between refreshes.
                if (pend_q || upd) begin
                  value_d = upd ? bus.data_in : pend_val_q;
                  pend_d  = 1'b0;
                  start_d = 1'b1;
                  state_d = StConv;
                end else begin
                  state_d = StIdle;
                end
              end else begin
                idx_d = idx_q + 3'd1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        endcase
      end
      default: state_d = StPowerup;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StPowerup;
      phase_q    <= PhSetup;
      cnt_q      <= '0;
      idx_q      <= '0;
      value_q    <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      start_q    <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      value_q    <= value_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      start_q    <= start_d;
      armed_q    <= 1'b1;
    end
  end

  assign bus.busy   = (state_q != StIdle);
  assign bus.lcd_rw = 1'b0;
  assign bus.lcd_rs = cur_rs;
  assign bus.lcd_db = cur_byte;
  assign bus.lcd_en = (state_q == StInit || state_q == StWrite) && (phase_q == PhEn);

endmodule
